// File: rtl/merge2_arb.sv
`default_nettype none
// ============================================================================
// Module   : merge2_arb
// Brief    : Two-input round-robin arbitrated merge into a small output FIFO;
//            every packet is tagged with the input it came from.
// Revision : 1.0 - initial release
// ============================================================================
module merge2_arb #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           l0_data,
  input  logic                       l0_valid,
  output logic                       l0_ready,
  input  logic [WIDTH-1:0]           l1_data,
  input  logic                       l1_valid,
  output logic                       l1_ready,
  output logic [WIDTH-1:0]           r_data,
  output logic                       r_src,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] C_PSTEP = AW'(1);

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_prio;

  logic             w_space;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_push;
  logic             w_pop;
  logic             w_src;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH:0]   w_head;

  // Grant follows prio only under contention; a lone requester always wins.
  assign w_space  = (r_count != C_DEPTH);
  assign w_gnt0   = l0_valid && (!l1_valid || !r_prio);
  assign w_gnt1   = l1_valid && (!l0_valid ||  r_prio);
  assign l0_ready = w_gnt0 && w_space && !rst;
  assign l1_ready = w_gnt1 && w_space && !rst;

  assign w_push = (l0_valid && l0_ready) || (l1_valid && l1_ready);
  assign w_src  = l1_valid && l1_ready;
  assign w_din  = w_src ? l1_data : l0_data;

  assign r_valid = (r_count != '0);
  assign w_pop   = r_valid && r_ready;
  assign count   = r_count;

  // Gating on r_valid keeps the output at zero after reset and whenever empty.
  assign w_head          = r_valid ? r_mem[r_rptr] : '0;
  assign {r_src, r_data} = w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PSTEP;
        r_prio <= ~w_src;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PSTEP;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_src, w_din};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_merge2_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_merge2_arb
// Brief    : Self-checking bench for merge2_arb with a reference scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_merge2_arb;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] l0_data, l1_data, r_data;
  logic             l0_valid, l0_ready, l1_valid, l1_ready;
  logic             r_src, r_valid, r_ready;
  logic [1:0]       count;

  int n_cmp = 0;
  int n_bad = 0;

  merge2_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .l0_data(l0_data), .l0_valid(l0_valid), .l0_ready(l0_ready),
    .l1_data(l1_data), .l1_valid(l1_valid), .l1_ready(l1_ready),
    .r_data(r_data), .r_src(r_src), .r_valid(r_valid), .r_ready(r_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: arbitration pointer plus a queue of expected {src,data}.
  logic [WIDTH:0] sb[$];
  logic           m_prio = 1'b0;
  logic           mon_en = 1'b0;
  logic           p_ok = 1'b0, p_rst, p_pop, p_push, p_src;
  logic [WIDTH-1:0] p_data;

  always @(negedge clk) begin
    logic e0, e1, sp;
    p_ok <= 1'b0;
    if (mon_en) begin
      sp = (sb.size() < DEPTH);
      e0 = l0_valid && (!l1_valid || !m_prio) && sp && !rst;
      e1 = l1_valid && (!l0_valid ||  m_prio) && sp && !rst;
      n_cmp++;
      if (l0_ready !== e0 || l1_ready !== e1) begin
        n_bad++;
        $display("FAIL sb_ready t=%0t: got l0=%b l1=%b want l0=%b l1=%b", $time, l0_ready, l1_ready, e0, e1);
      end
      n_cmp++;
      if (r_valid !== (sb.size() != 0) || count !== 2'(sb.size())) begin
        n_bad++;
        $display("FAIL sb_occupancy t=%0t: got valid=%b count=%0d want count=%0d", $time, r_valid, count, sb.size());
      end
      if (sb.size() != 0) begin
        n_cmp++;
        if ({r_src, r_data} !== sb[0]) begin
          n_bad++;
          $display("FAIL sb_head t=%0t: got src=%b data=%h want src=%b data=%h", $time, r_src, r_data, sb[0][WIDTH], sb[0][WIDTH-1:0]);
        end
      end
      p_ok   <= 1'b1;
      p_rst  <= rst;
      p_pop  <= (sb.size() != 0) && r_ready;
      p_push <= e0 || e1;
      p_src  <= e1;
      p_data <= e1 ? l1_data : l0_data;
    end
  end

  always @(posedge clk) begin
    if (p_ok) begin
      if (p_rst) begin
        sb.delete();
        m_prio <= 1'b0;
      end else begin
        if (p_pop) void'(sb.pop_front());
        if (p_push) begin
          sb.push_back({p_src, p_data});
          m_prio <= ~p_src;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; l0_valid = 1'b0; l1_valid = 1'b0; r_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; l0_valid = 1'b1; l0_data = 4'hA; l1_valid = 1'b0; l1_data = '0; r_ready = 1'b0;
    tick; mon_en = 1'b1; tick;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd0 || r_valid !== 1'b0 || r_data !== 4'h0 || r_src !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: got count=%0d valid=%b data=%h src=%b want 0 0 0 0", count, r_valid, r_data, r_src);
    end
    n_cmp++;
    if (l0_ready !== 1'b0 || l1_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got l0=%b l1=%b want 0 0", l0_ready, l1_ready);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (l0_ready !== 1'b1) begin
      n_bad++; $display("FAIL first_accept: got l0_ready=%b want 1", l0_ready);
    end
    tick; l0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 4'hA || r_src !== 1'b0) begin
      n_bad++; $display("FAIL first_latency: got valid=%b data=%h src=%b want 1 a 0", r_valid, r_data, r_src);
    end
    tick; r_ready = 1'b1; tick; r_ready = 1'b0;
  endtask

  task automatic test_contention;
    logic [WIDTH-1:0] d0[3] = '{4'd1, 4'd2, 4'd3};
    logic [WIDTH-1:0] d1[3] = '{4'd9, 4'd8, 4'd7};
    logic [WIDTH:0]   ex[6] = '{5'h01, 5'h19, 5'h02, 5'h18, 5'h03, 5'h17};
    logic [WIDTH:0]   obs[$];
    int i0 = 0, i1 = 0;
    logic g0, g1;
    apply_reset;
    r_ready = 1'b1;
    l0_valid = 1'b1; l0_data = d0[0];
    l1_valid = 1'b1; l1_data = d1[0];
    for (int c = 0; c < 30 && obs.size() < 6; c++) begin
      @(negedge clk);
      g0 = l0_valid && l0_ready;
      g1 = l1_valid && l1_ready;
      if (r_valid && r_ready) obs.push_back({r_src, r_data});
      tick;
      if (g0) i0++;
      if (g1) i1++;
      l0_valid = (i0 < 3); if (i0 < 3) l0_data = d0[i0];
      l1_valid = (i1 < 3); if (i1 < 3) l1_data = d1[i1];
    end
    l0_valid = 1'b0; l1_valid = 1'b0;
    n_cmp++;
    if (obs.size() != 6) begin
      n_bad++; $display("FAIL contention_timeout: got %0d outputs want 6", obs.size());
    end
    for (int k = 0; k < 6 && k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== ex[k]) begin
        n_bad++; $display("FAIL contention_order[%0d]: got src=%b data=%h want src=%b data=%h", k, obs[k][WIDTH], obs[k][WIDTH-1:0], ex[k][WIDTH], ex[k][WIDTH-1:0]);
      end
    end
    tick; tick;
  endtask

  task automatic test_prio_update;
    apply_reset;
    r_ready = 1'b1;
    l1_valid = 1'b1; l1_data = 4'd5;
    @(negedge clk);
    n_cmp++;
    if (l1_ready !== 1'b1) begin
      n_bad++; $display("FAIL prio_single: got l1_ready=%b want 1", l1_ready);
    end
    tick;
    l0_valid = 1'b1; l0_data = 4'd6; l1_data = 4'd7;
    @(negedge clk);
    n_cmp++;
    if (l0_ready !== 1'b1 || l1_ready !== 1'b0) begin
      n_bad++; $display("FAIL prio_moved: got l0=%b l1=%b want 1 0", l0_ready, l1_ready);
    end
    tick; l0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (l1_ready !== 1'b1) begin
      n_bad++; $display("FAIL prio_second: got l1_ready=%b want 1", l1_ready);
    end
    tick; l1_valid = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_full;
    apply_reset;
    l0_valid = 1'b1; l0_data = 4'd1;
    tick; l0_data = 4'd2;
    tick; l0_data = 4'd3;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd2 || l0_ready !== 1'b0 || r_data !== 4'd1) begin
      n_bad++; $display("FAIL full_stall: got count=%0d l0_ready=%b data=%h want 2 0 1", count, l0_ready, r_data);
    end
    tick; r_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (l0_ready !== 1'b0 || count !== 2'd2) begin
      n_bad++; $display("FAIL full_pop_same_cycle: got l0_ready=%b count=%0d want 0 2", l0_ready, count);
    end
    tick; r_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (l0_ready !== 1'b1 || count !== 2'd1 || r_data !== 4'd2) begin
      n_bad++; $display("FAIL full_freed_slot: got l0_ready=%b count=%0d data=%h want 1 1 2", l0_ready, count, r_data);
    end
    tick; l0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd2) begin
      n_bad++; $display("FAIL full_refill: got count=%0d want 2", count);
    end
    tick; r_ready = 1'b1; tick; tick; tick; r_ready = 1'b0;
  endtask

  task automatic test_push_pop;
    apply_reset;
    l0_valid = 1'b1; l0_data = 4'd1;
    tick; l0_data = 4'd3; r_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd1 || l0_ready !== 1'b1 || r_data !== 4'd1) begin
      n_bad++; $display("FAIL pushpop_before: got count=%0d l0_ready=%b data=%h want 1 1 1", count, l0_ready, r_data);
    end
    tick; l0_valid = 1'b0; r_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd1 || r_data !== 4'd3 || r_src !== 1'b0) begin
      n_bad++; $display("FAIL pushpop_after: got count=%0d data=%h src=%b want 1 3 0", count, r_data, r_src);
    end
    tick; r_ready = 1'b1; tick; r_ready = 1'b0;
  endtask

  task automatic test_midreset;
    apply_reset;
    l0_valid = 1'b1; l0_data = 4'd4;
    tick; l0_data = 4'd5;
    tick; l0_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd2) begin
      n_bad++; $display("FAIL midrst_fill: got count=%0d want 2", count);
    end
    tick; rst = 1'b1; l1_valid = 1'b1; l1_data = 4'd6;
    @(negedge clk);
    n_cmp++;
    if (l0_ready !== 1'b0 || l1_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_ready: got l0=%b l1=%b want 0 0", l0_ready, l1_ready);
    end
    tick; rst = 1'b0; l1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (count !== 2'd0 || r_valid !== 1'b0 || r_data !== 4'd0) begin
      n_bad++; $display("FAIL midrst_cleared: got count=%0d valid=%b data=%h want 0 0 0", count, r_valid, r_data);
    end
    tick; l0_valid = 1'b1; l0_data = 4'd7; l1_valid = 1'b1; l1_data = 4'd8;
    @(negedge clk);
    n_cmp++;
    if (l0_ready !== 1'b1 || l1_ready !== 1'b0) begin
      n_bad++; $display("FAIL midrst_prio: got l0=%b l1=%b want 1 0", l0_ready, l1_ready);
    end
    tick; l0_valid = 1'b0; l1_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r_valid !== 1'b1 || r_data !== 4'd7 || r_src !== 1'b0) begin
      n_bad++; $display("FAIL midrst_fresh: got valid=%b data=%h src=%b want 1 7 0", r_valid, r_data, r_src);
    end
    tick; r_ready = 1'b1;
  endtask

  initial begin
    test_reset;
    test_contention;
    test_prio_update;
    test_full;
    test_push_pop;
    test_midreset;
    r_ready = 1'b1;
    repeat (4) tick;
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || count !== 2'd0) begin
      n_bad++; $display("FAIL final_drain: got count=%0d pending=%0d want 0 0", count, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/merge2_arb.md
# merge2_arb

Clocked two-input arbitrated merge: the converging counterpart of the PE fan-out `copy` stage. It accepts packets from two valid/ready input channels, L0 and L1, at most one per cycle. Round-robin arbitration decides which input wins when both are offered. Accepted packets go into a small output FIFO that drives a single valid/ready output channel R, and each packet is tagged with the input it came from. It sits where two PE result streams must share one downstream link in the clocked (gate-level) flow.

## Interface
- WIDTH, 4, packet data width in bits
- DEPTH, 2, output FIFO entries; power of two, at least 2
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- l0_data  input  WIDTH  channel L0 packet
- l0_valid  input  1  L0 offers a packet
- l0_ready  output  1  L0 packet is accepted this cycle
- l1_data  input  WIDTH  channel L1 packet
- l1_valid  input  1  L1 offers a packet
- l1_ready  output  1  L1 packet is accepted this cycle
- r_data  output  WIDTH  head-of-FIFO packet
- r_src  output  1  source of r_data: 0 = L0, 1 = L1
- r_valid  output  1  FIFO is non-empty
- r_ready  input  1  downstream consumes the head this cycle
- count  output  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- A transfer on any channel occurs on a rising clk edge where valid && ready are both high.
- Priority pointer `prio` (1 bit) names the favoured input.
- Grant rule (combinational; evaluated only when count < DEPTH):
  - Both inputs valid: grant the input named by `prio`.
  - Exactly one input valid: grant that input.
  - Neither valid: no grant.
- `lX_ready` = grant to X && count < DEPTH && !rst. The non-granted input always sees ready = 0.
- After an accepted packet from input X, `prio` is set to the other input. With no acceptance, `prio` holds.
- Push writes {src, data} at the write pointer. Pop on r_valid && r_ready advances the read pointer.
- Pointers wrap modulo DEPTH. Each pointer carries an extra wrap bit, or full/empty is tracked from `count`.
- count update per cycle:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together: count unchanged, and both pointers advance
- There is no input-to-output bypass: data always passes through the FIFO.
- While r_valid && !r_ready, r_data and r_src must hold stable.
- Input data is never dropped or duplicated. Packet order is preserved per source and matches grant order globally.

## Timing
- Reset (rst high at a clk edge):
  - count = 0, r_valid = 0, r_data = 0, r_src = 0, prio = 0 (L0 favoured), both pointers = 0
  - l0_ready = l1_ready = 0 while rst is high
- Reset asserted mid-operation discards all FIFO contents on that edge. Packets offered in that cycle are not accepted.
- Latency: a packet accepted at edge N is visible on r_valid/r_data after edge N, i.e. one cycle, when the FIFO was empty.
- Full (count == DEPTH): both readies are 0, even if r_ready is high in the same cycle. A freed slot becomes usable from the next cycle.
- Empty (count == 0): r_valid = 0, and r_ready is ignored.
- Throughput: one packet per cycle sustained when r_ready stays high. With both inputs valid continuously, the grants alternate L0, L1, L0, …

## Test plan
- Reset then idle: rst high 2 cycles -> count=0, r_valid=0, r_data=0, readies 0. Release rst with l0_valid=1, l0_data=4'hA -> l0_ready=1, next cycle r_valid=1, r_data=A, r_src=0.
- Contention: both valid continuously (L0 sends 1,2,3; L1 sends 9,8,7), r_ready=1 -> output order 1,9,2,8,3,7 with r_src 0,1,0,1,0,1.
- Pointer update with one source: L1 alone sends 5. Next cycle both valid (L0=6, L1=7) -> L0 is granted first (prio moved to L0), then L1.
- Backpressure and full: r_ready=0, L0 sends 1 then 2 -> count=2, l0_ready=0 on the third offer, r_data stays 1. Raise r_ready -> 1 is popped, and L0's third packet is accepted the following cycle.
- Simultaneous push/pop at count=1: push 3 while popping 1 -> count stays 1, and next r_data=3.
- Mid-stream reset with count=2: assert rst one cycle -> count=0, r_valid=0, prio=0. A subsequent packet emerges with no stale data.
